// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
//
// Shared definitions for the multi-bit right-shift sequencer:
//   seq_state_t  - controller FSM states (IDLE, SHIFT, DONE)
//   MODE_ARITH   - shift fill is the operand MSB (sign extension)
//   MODE_LOGIC   - shift fill is zero
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage : shift_pkg

// File: rtl/right_shift_register.sv
// -----------------------------------------------------------------------------
// right_shift_register
//
// Single-step right shifter with an output register. On every clock edge the
// register captures either its input unshifted (enable = 0) or its input
// shifted right by one position (enable = 1).
//
// Ports:
//   clk     in   1      clock
//   enable  in   1      1 = shift by one, 0 = load unshifted
//   mode    in   1      MODE_LOGIC = zero fill, MODE_ARITH = replicate MSB
//   d       in   width  register input
//   dout    out  width  register contents
// -----------------------------------------------------------------------------
module right_shift_register
    import shift_pkg::*;
#(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             enable,
    input  logic             mode,
    input  logic [width-1:0] d,
    output logic [width-1:0] dout
);

    logic fill;

    assign fill = (mode == MODE_LOGIC) ? 1'b0 : d[width-1];

    // NOTE: this is a pure datapath register with no reset of its own; the
    // controller clears it by steering zero onto d while reset is asserted.
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (enable) begin
            dout <= {fill, d[width-1:1]};
        end else begin
            dout <= d;
        end
    end

endmodule : right_shift_register

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle right-shift controller. A one-cycle start accepted in IDLE loads
// the operand into the shift register, then the register is stepped right once
// per cycle for min(amount, width) cycles. done pulses for one cycle when the
// result is ready; the result is then held until the next accepted start.
//
// Ports:
//   clk     in   1      clock
//   reset   in   1      synchronous, active-high; aborts any operation and
//                       clears dout
//   start   in   1      request, only sampled in IDLE
//   din     in   width  operand
//   amount  in   AW     shift distance (values above width are clamped)
//   mode    in   1      MODE_ARITH (0) or MODE_LOGIC (1)
//   busy    out  1      high while not IDLE
//   done    out  1      one-cycle completion pulse
//   dout    out  width  shift register contents / result
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int width = 16,
    parameter int AW    = $clog2(width) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] din,
    input  logic [AW-1:0]    amount,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] dout
);

    localparam logic [AW-1:0] WIDTH_AMT = AW'(width);

    seq_state_t       state, state_next;
    logic [AW-1:0]    cnt, cnt_next;
    logic             mode_q, mode_next;
    logic [AW-1:0]    amt_clamped;

    // Register steering.
    logic [width-1:0] reg_d;
    logic             reg_en;

    assign amt_clamped = (amount > WIDTH_AMT) ? WIDTH_AMT : amount;

    // -------------------------------------------------------------------------
    // Controller state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= MODE_ARITH;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            mode_q <= mode_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, counter, latched mode and register input mux
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a signal unassigned and infer a latch.
        state_next = state;
        cnt_next   = cnt;
        mode_next  = mode_q;
        reg_d      = dout;      // hold
        reg_en     = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    reg_d      = din;   // load
                    mode_next  = mode;
                    cnt_next   = amt_clamped;
                    state_next = (amt_clamped == '0) ? DONE : SHIFT;
                end
            end

            SHIFT: begin
                reg_en   = 1'b1;        // shift dout by one
                cnt_next = cnt - AW'(1);
                if (cnt == AW'(1)) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Reset overrides everything: clear the register and suppress done so
        // an aborted operation never reports completion.
        if (reset) begin
            reg_d  = '0;
            reg_en = 1'b0;
            done   = 1'b0;
        end
    end

    assign busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // Shift datapath
    // -------------------------------------------------------------------------
    right_shift_register #(
        .width (width)
    ) u_shift_reg (
        .clk    (clk),
        .enable (reg_en),
        .mode   (mode_q),
        .d      (reg_d),
        .dout   (dout)
    );

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Scoreboard bench: the driver pushes the expected result and completion cycle
// of every accepted request; an independent monitor compares on each done
// pulse and checks that dout holds while idle.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;
    import shift_pkg::*;

    localparam int W  = 16;
    localparam int AW = $clog2(W) + 1;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start  = 1'b0;
    logic [W-1:0]  din    = '0;
    logic [AW-1:0] amount = '0;
    logic          mode   = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  dout;

    shift_sequencer #(.width(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .din    (din),
        .amount (amount),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .dout   (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] val;
        int           at;
        int           k;
    } exp_t;

    exp_t         sb[$];
    int           errors   = 0;
    int           checks   = 0;
    logic [W-1:0] hold_val = '0;
    bit           mon_en   = 1'b0;
    int           busy_run = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: shifting by k is division-like arithmetic on a widened value.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int a, input logic m);
        int k;
        logic signed [31:0] s;
        logic [31:0] u;
        k = (a > W) ? W : a;
        if (m == MODE_LOGIC) begin
            u = {16'b0, d};
            u = u >> k;
            return u[W-1:0];
        end
        s = {{16{d[W-1]}}, d};
        s = s >>> k;
        return s[W-1:0];
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(dout), 32'(e.val));
                    check("done_cycle", 32'(cyc), 32'(e.at));
                    check("busy_len", 32'(busy_run), 32'(e.k + 1));
                    hold_val = e.val;
                end
            end else if (!busy) begin
                check("hold", 32'(dout), 32'(hold_val));
                busy_run = 0;
            end
        end
    end

    // Drive one request starting at a negedge when idle; returns at the
    // negedge following the accepting edge (E0).
    task automatic issue(input logic [W-1:0] d, input int a, input logic m, input bit push = 1'b1);
        int n;
        int k;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'(0));
        din    = d;
        amount = AW'(a);
        mode   = m;
        start  = 1'b1;
        k = (a > W) ? W : a;
        if (push) sb.push_back('{val: model(d, a, m), at: cyc + 1 + k, k: k});
        @(negedge clk);
        start  = 1'b0;
        // Scramble inputs after acceptance; they must have no effect.
        din    = W'($urandom);
        amount = AW'($urandom);
        mode   = 1'($urandom);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_dout", 32'(dout), 32'(0));
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed cases
        issue(16'h8000, 3, MODE_LOGIC);
        issue(16'h8000, 3, MODE_ARITH);
        issue(16'hABCD, 0, MODE_ARITH);
        issue(16'h8001, 20, MODE_ARITH);
        issue(16'h8001, 20, MODE_LOGIC);
        issue(16'h8001, 16, MODE_ARITH);
        issue(16'h7FFF, 15, MODE_ARITH);

        // Reset mid-operation: amount 8, reset asserted after E3
        issue(16'hC3A5, 8, MODE_ARITH, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        hold_val = '0;
        @(negedge clk);
        check("abort_dout", 32'(dout), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        reset = 1'b0;
        repeat (12) @(negedge clk);

        // Disturbances during a shift by 4 must be ignored
        issue(16'h9234, 4, MODE_ARITH);
        mode  = MODE_LOGIC;
        din   = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_done_seen", 32'(done), 32'(1));
        din    = 16'h5555;
        amount = AW'(2);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_start_ignored", 32'(busy), 32'(0));
        issue(16'h00F0, 2, MODE_LOGIC);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), int'($urandom_range(0, 31)), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Drain
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_sequencer
